binary_to_bcd: RTL

//   Sequential double-dabble converter: unsigned binary value -> packed BCD digits.

---
 rtl/binary_to_bcd_pkg.sv | 25 ++
 rtl/binary_to_bcd_digit_adjust.sv | 21 ++
 rtl/binary_to_bcd.sv | 123 ++++++++++++
 3 files changed

// File: rtl/binary_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd_pkg
// Purpose  : Shared constants for the double-dabble binary-to-BCD converter:
//            FSM state encodings and the per-digit adjust threshold/increment.
// Revision : 1.0 - initial release
// ============================================================================
package binary_to_bcd_pkg;

  // Converter control states; one bit is enough for IDLE/SHIFT.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } bcd_state_t;

  // A digit at or above this value would reach 10 or more when doubled,
  // so it is pre-corrected before the shift.
  localparam logic [3:0] BCD_ADJ_THRESHOLD = 4'd5;

  // Adding 3 before doubling equals adding 6 after doubling, which is the
  // decimal-carry correction for a 4-bit digit.
  localparam logic [3:0] BCD_ADJ_ADD = 4'd3;

endpackage : binary_to_bcd_pkg
`default_nettype wire

// File: rtl/binary_to_bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adjust
// Purpose  : Combinational double-dabble cell: a 4-bit BCD digit of 5..9 is
//            incremented by 3, anything below 5 passes through unchanged.
//            The result (at most 12) always fits in 4 bits, so no carry is
//            ever propagated to the neighbouring digit.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
  import binary_to_bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= BCD_ADJ_THRESHOLD) ? (digit_i + BCD_ADJ_ADD)
                                                  : digit_i;

endmodule : bcd_digit_adjust
`default_nettype wire

// File: rtl/binary_to_bcd.sv
`default_nettype none
// ============================================================================
// Module   : binary_to_bcd
// Purpose  : Sequential double-dabble converter. One input bit is consumed
//            per clock; after INPUT_WIDTH shift cycles the packed BCD result
//            ([3:0]=ones, [7:4]=tens, ...) is published together with an
//            overflow flag and a one-cycle done pulse. Values that do not fit
//            in DIGITS digits are reported modulo 10**DIGITS with overflow set.
// Revision : 1.0 - initial release
// ============================================================================
module binary_to_bcd
  import binary_to_bcd_pkg::*;
#(
  parameter int INPUT_WIDTH = 8,
  parameter int DIGITS      = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [INPUT_WIDTH-1:0]  i_binary,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [DIGITS*4-1:0]     o_bcd,
  output logic                    o_overflow
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(INPUT_WIDTH + 1);
  // Count value seen on the final shift edge of a conversion.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INPUT_WIDTH - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  bcd_state_t                state_q;
  logic [INPUT_WIDTH-1:0]    bin_q;      // remaining binary bits, MSB first
  logic [BCD_W-1:0]          work_q;     // BCD accumulator during conversion
  logic                      ovf_q;      // sticky: a bit fell off the top digit
  logic [CNT_W-1:0]          cnt_q;      // shifts completed so far
  logic                      busy_q;
  logic                      done_q;
  logic [BCD_W-1:0]          bcd_q;      // published result, held between runs
  logic                      ovf_out_q;  // published overflow flag

  // --------------------------------------------------------------------------
  // Next-step datapath: adjust every digit in parallel, then shift the
  // {work, bin} pair left by one. The bit leaving the top digit is the
  // carry into the (non-existent) next decimal digit.
  // --------------------------------------------------------------------------
  logic [BCD_W-1:0]             adj_d;
  logic [BCD_W+INPUT_WIDTH-1:0] cat_d;
  logic [BCD_W-1:0]             work_d;
  logic [INPUT_WIDTH-1:0]       bin_d;
  logic                         ovf_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_adjust u_adj (
      .digit_i (work_q[g*4 +: 4]),
      .digit_o (adj_d[g*4 +: 4])
    );
  end

  assign cat_d  = {adj_d, bin_q} << 1;
  assign work_d = cat_d[BCD_W+INPUT_WIDTH-1:INPUT_WIDTH];
  assign bin_d  = cat_d[INPUT_WIDTH-1:0];
  assign ovf_d  = ovf_q | adj_d[BCD_W-1];

  // Control FSM, shift registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bin_q     <= '0;
      work_q    <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      // Done is a pulse: dropped on every edge unless re-asserted below.
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            bin_q   <= i_binary;
            work_q  <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // i_start is deliberately not looked at here: no queueing.
          work_q <= work_d;
          bin_q  <= bin_d;
          ovf_q  <= ovf_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            bcd_q     <= work_d;
            ovf_out_q <= ovf_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_bcd      = bcd_q;
  assign o_overflow = ovf_out_q;

endmodule : binary_to_bcd
`default_nettype wire
